// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - size encodings, LSU state enum and lane constants
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LD,
    ST_MRG,
    ST_WR,
    ST_ERR
  } lsu_state_e;

  // Illegal size is folded in here so one call covers every encoding error.
  function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and merge for sub-word stores
module lsu_lane
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       size,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] old_data,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] merge_data
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: BYTE_W];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: HALF_W];
    case (size)
      SZ_BYTE: load_data = {{(WIDTH-BYTE_W){is_signed & byte_sel[BYTE_W-1]}}, byte_sel};
      SZ_HALF: load_data = {{(WIDTH-HALF_W){is_signed & half_sel[HALF_W-1]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = old_data;
    case (size)
      SZ_BYTE: merge_data[{addr_lo, 3'b000} +: BYTE_W]   = wdata[BYTE_W-1:0];
      SZ_HALF: merge_data[{addr_lo[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit in front of dmemory with RMW sub-word stores
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             mem_write,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_data
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  lsu_state_e       state_q, state_d;
  logic             write_q, signed_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic             accept;
  logic             req_bad;
  logic [WIDTH-1:0] word_idx;
  logic [WIDTH-1:0] load_data, merge_data;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_bad   = bad_align(req_size, req_addr[1:0]) |
                     ({2'b00, req_addr[WIDTH-1:2]} >= DEPTH_W);
  assign word_idx  = {2'b00, addr_q[WIDTH-1:2]};

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // old_data and rdata are both the fetched word: one lane block serves LD and MRG.
  lsu_lane #(.WIDTH(WIDTH)) u_lane (
    .rdata      (mem_data),
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .old_data   (mem_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      write_q  <= req_write;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)                              state_d = ST_ERR;
          else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
          else                                       state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_read    = 1'b1;
        mem_address = word_idx;
        state_d     = write_q ? ST_MRG : ST_LD;
      end
      ST_LD: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
        state_d      = ST_IDLE;
      end
      ST_MRG: begin
        mem_write      = 1'b1;
        mem_address    = word_idx;
        mem_write_data = merge_data;
        resp_valid_d   = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_WR: begin
        mem_write      = 1'b1;
        mem_address    = word_idx;
        mem_write_data = wdata_q;
        resp_valid_d   = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_address, mem_write_data, mem_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int both_cnt = 0;

  logic [31:0] mem [0:1023];

  logic        o_rd  [1:3];
  logic        o_wr  [1:3];
  logic [31:0] o_adr [1:3];
  logic [31:0] o_wd  [1:3];
  logic        o_rv  [1:3];
  logic        o_err [1:3];
  logic [31:0] o_rdt [1:3];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } req_t;

  req_t sq [8];

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_data       (mem_data)
  );

  always #5 clk = ~clk;

  // dmemory stand-in: synchronous write, read data registered one cycle after mem_read
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    if (mem_read)  mem_data <= mem[mem_address[9:0]];
  end

  always @(negedge clk) if (mem_read && mem_write) both_cnt++;

  function automatic req_t mk(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    req_t r;
    r.w = w; r.sz = sz; r.sg = sg; r.a = a; r.wd = wd; r.exp_rd = er; r.exp_err = ee;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; records cycles T+1..T+3 and returns at negedge of T+3.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      o_rd[c] = mem_read;   o_wr[c] = mem_write;
      o_adr[c] = mem_address; o_wd[c] = mem_write_data;
      o_rv[c] = resp_valid; o_err[c] = resp_err; o_rdt[c] = resp_rdata;
      if (c < 3) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    vec_cnt++; if (req_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    vec_cnt++; if (resp_valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vec_cnt++; if (resp_err !== 1'b0) begin miss_cnt++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    vec_cnt++; if (resp_rdata !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    vec_cnt++; if ({mem_read, mem_write} !== 2'b00) begin miss_cnt++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
    vec_cnt++; if (mem_address !== 32'h0 || mem_write_data !== 32'h0) begin miss_cnt++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_address, mem_write_data); end
  endtask

  task automatic test_word();
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    vec_cnt++; if (o_wr[1] !== 1'b1 || o_rd[1] !== 1'b0) begin miss_cnt++; $display("FAIL sw_strobe_t1: got rd=%b wr=%b expected rd=0 wr=1", o_rd[1], o_wr[1]); end
    vec_cnt++; if (o_adr[1] !== 32'd4) begin miss_cnt++; $display("FAIL sw_address: got %h expected 4", o_adr[1]); end
    vec_cnt++; if (o_wd[1] !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL sw_wdata: got %h expected deadbeef", o_wd[1]); end
    vec_cnt++; if (o_rv[1] !== 1'b0 || o_rv[2] !== 1'b1 || o_err[2] !== 1'b0) begin miss_cnt++; $display("FAIL sw_resp_t2: got v1=%b v2=%b e2=%b expected 0 1 0", o_rv[1], o_rv[2], o_err[2]); end
    vec_cnt++; if (o_wr[2] !== 1'b0) begin miss_cnt++; $display("FAIL sw_single_write: got %b expected 0", o_wr[2]); end

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    vec_cnt++; if (o_rd[1] !== 1'b1 || o_adr[1] !== 32'd4) begin miss_cnt++; $display("FAIL lw_read_t1: got rd=%b adr=%h expected 1 4", o_rd[1], o_adr[1]); end
    vec_cnt++; if (o_rv[2] !== 1'b0 || o_rv[3] !== 1'b1) begin miss_cnt++; $display("FAIL lw_resp_t3: got v2=%b v3=%b expected 0 1", o_rv[2], o_rv[3]); end
    vec_cnt++; if (o_rdt[3] !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL lw_rdata: got %h expected deadbeef", o_rdt[3]); end
  endtask

  task automatic test_byte();
    mem[4] = 32'h11223344;
    run_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5);
    vec_cnt++; if (o_rd[1] !== 1'b1 || o_wr[1] !== 1'b0) begin miss_cnt++; $display("FAIL sb_read_t1: got rd=%b wr=%b expected 1 0", o_rd[1], o_wr[1]); end
    vec_cnt++; if (o_wr[2] !== 1'b1 || o_wd[2] !== 32'hA5223344) begin miss_cnt++; $display("FAIL sb_merge_t2: got wr=%b data=%h expected 1 a5223344", o_wr[2], o_wd[2]); end
    vec_cnt++; if (o_rv[3] !== 1'b1 || o_rdt[3] !== 32'h0) begin miss_cnt++; $display("FAIL sb_resp_t3: got v=%b rd=%h expected 1 0", o_rv[3], o_rdt[3]); end
    vec_cnt++; if (mem[4] !== 32'hA5223344) begin miss_cnt++; $display("FAIL sb_mem: got %h expected a5223344", mem[4]); end

    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'hFFFFFFA5) begin miss_cnt++; $display("FAIL lb: got %h expected ffffffa5", o_rdt[3]); end
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'h000000A5) begin miss_cnt++; $display("FAIL lbu: got %h expected 000000a5", o_rdt[3]); end
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'h00000033) begin miss_cnt++; $display("FAIL lb_lane1: got %h expected 00000033", o_rdt[3]); end
  endtask

  task automatic test_half();
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001);
    vec_cnt++; if (o_wr[2] !== 1'b1 || o_wd[2] !== 32'h80013344) begin miss_cnt++; $display("FAIL sh_merge: got wr=%b data=%h expected 1 80013344", o_wr[2], o_wd[2]); end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'hFFFF8001) begin miss_cnt++; $display("FAIL lh: got %h expected ffff8001", o_rdt[3]); end
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'h00003344) begin miss_cnt++; $display("FAIL lhu: got %h expected 00003344", o_rdt[3]); end
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    vec_cnt++; if (o_rdt[3] !== 32'h00000044) begin miss_cnt++; $display("FAIL lb_lane0: got %h expected 00000044", o_rdt[3]); end
  endtask

  task automatic test_errors();
    logic        ew  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  esz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] ea  [5] = '{32'h11, 32'h13, 32'h10, 32'h1000, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      run_req(ew[i], esz[i], 1'b1, ea[i], 32'hCAFEF00D);
      vec_cnt++;
      if (o_rv[1] !== 1'b0 || o_rv[2] !== 1'b1 || o_err[2] !== 1'b1 || o_rdt[2] !== 32'h0)
        begin miss_cnt++; $display("FAIL err_resp[%0d]: got v1=%b v2=%b e=%b rd=%h expected 0 1 1 0", i, o_rv[1], o_rv[2], o_err[2], o_rdt[2]); end
      vec_cnt++;
      if ({o_rd[1], o_wr[1], o_rd[2], o_wr[2], o_rd[3], o_wr[3]} !== 6'b0)
        begin miss_cnt++; $display("FAIL err_strobes[%0d]: got %b expected 000000", i, {o_rd[1], o_wr[1], o_rd[2], o_wr[2], o_rd[3], o_wr[3]}); end
    end
    mem[1023] = 32'h5A5A0F0F;
    run_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    vec_cnt++;
    if (o_rd[1] !== 1'b1 || o_adr[1] !== 32'd1023 || o_rv[3] !== 1'b1 || o_rdt[3] !== 32'h5A5A0F0F)
      begin miss_cnt++; $display("FAIL last_word: got rd=%b adr=%h v=%b rd=%h expected 1 3ff 1 5a5a0f0f", o_rd[1], o_adr[1], o_rv[3], o_rdt[3]); end
  endtask

  task automatic test_reset_rmw();
    mem[5] = 32'h55667788;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if (mem_write !== 1'b1) begin miss_cnt++; $display("FAIL rmw_in_mrg: got %b expected 1", mem_write); end
    #1 rst = 1'b1;
    #1;
    vec_cnt++; if ({mem_read, mem_write} !== 2'b00 || mem_address !== 32'h0) begin miss_cnt++; $display("FAIL rmw_async_drop: got %b adr=%h expected 00 0", {mem_read, mem_write}, mem_address); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vec_cnt++; if (req_ready !== 1'b1) begin miss_cnt++; $display("FAIL rmw_ready: got %b expected 1", req_ready); end
    for (int c = 0; c < 4; c++) begin
      vec_cnt++; if (resp_valid !== 1'b0) begin miss_cnt++; $display("FAIL rmw_no_resp[%0d]: got %b expected 0", c, resp_valid); end
      @(negedge clk);
    end
    vec_cnt++; if (mem[5] !== 32'h55667788) begin miss_cnt++; $display("FAIL rmw_mem_kept: got %h expected 55667788", mem[5]); end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int done   = 0;
    int cyc    = 0;
    sq[0] = mk(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, 32'h0,        1'b0);
    sq[1] = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h01020304, 1'b0);
    sq[2] = mk(1'b1, 2'b00, 1'b0, 32'h21, 32'h000077FF, 32'h0,        1'b0);
    sq[3] = mk(1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'h000000FF, 1'b0);
    sq[4] = mk(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h0,        1'b0);
    sq[5] = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hBEEFFF04, 1'b0);
    sq[6] = mk(1'b0, 2'b10, 1'b0, 32'h23, 32'h0,        32'h0,        1'b1);
    sq[7] = mk(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b0);
    while (done < 8 && cyc < 200) begin
      if (resp_valid === 1'b1) begin
        vec_cnt++;
        if (resp_rdata !== sq[done].exp_rd || resp_err !== sq[done].exp_err)
          begin miss_cnt++; $display("FAIL b2b_resp[%0d]: got rd=%h e=%b expected %h %b", done, resp_rdata, resp_err, sq[done].exp_rd, sq[done].exp_err); end
        done++;
      end
      if (req_ready === 1'b1 && issued < 8) begin
        if (issued > 0) begin
          vec_cnt++;
          if (resp_valid !== 1'b1) begin miss_cnt++; $display("FAIL b2b_accept[%0d]: got resp_valid=%b expected 1", issued, resp_valid); end
        end
        req_valid = 1'b1; req_write = sq[issued].w; req_size = sq[issued].sz;
        req_signed = sq[issued].sg; req_addr = sq[issued].a; req_wdata = sq[issued].wd;
        issued++;
      end else if (req_ready === 1'b1) begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    vec_cnt++; if (done != 8) begin miss_cnt++; $display("FAIL b2b_timeout: got %0d responses expected 8", done); end
    vec_cnt++; if (both_cnt != 0) begin miss_cnt++; $display("FAIL both_strobes: got %0d cycles expected 0", both_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem_data  = 32'h0;
    rst       = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr  = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_rmw();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the MEM pipeline stage and `dmemory`. Accepts one byte/halfword/word load or store per request, converts byte addresses to `dmemory` word indices, and extracts and sign- or zero-extends load data. Sub-word stores are done as read-modify-write because `dmemory` has no byte enables. Misaligned and out-of-range accesses are rejected before any memory strobe is driven.

## Interface
- `WIDTH`, 32, data and address width; must match `dmemory`.
- `DEPTH`, 1024, `dmemory` depth in words; word index ≥ `DEPTH` is out of range.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  MEM-stage request present
- `req_ready`  out  1  unit idle; request accepted on `req_valid & req_ready` at posedge
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_signed`  in  1  loads: 1 = sign-extend, 0 = zero-extend
- `req_addr`  in  WIDTH  byte address
- `req_wdata`  in  WIDTH  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  qualified by `resp_valid`; misaligned, illegal size or out of range
- `resp_rdata`  out  WIDTH  load result; 0 for stores and errors
- `mem_write`, `mem_read`  out  1 each  to `dmemory`
- `mem_address`  out  WIDTH  word index `{2'b00, addr[WIDTH-1:2]}`
- `mem_write_data`  out  WIDTH  to `dmemory`
- `mem_data`  in  WIDTH  from `dmemory`; valid the cycle after `mem_read`

## Operation
- **States:** IDLE, RD, LD, MRG, WR, ERR. `req_ready = (state == IDLE)`.
- **Accept:** on accept, capture `write`, `size`, `signed`, `addr` and `wdata`. Request inputs are ignored when `req_ready` is low.
- **Error check at accept:** half with `addr[0] = 1`, word with `addr[1:0] != 0`, size 11, or `addr[WIDTH-1:2] ≥ DEPTH` all go to ERR.
- **Valid requests:**
  - Load → RD.
  - Word store → WR.
  - Byte or half store → RD.
- **Transitions:**
  - RD: `mem_read = 1`. Next state is LD for a load, MRG for a store.
  - LD: select the lane from `mem_data` and extend it into the response register. Next state IDLE.
  - MRG: `mem_write = 1`, `mem_write_data` = `mem_data` with the target lane replaced by the low bits of `wdata`. Next state IDLE.
  - WR: `mem_write = 1`, `mem_write_data = wdata`. Next state IDLE.
  - ERR: no strobes; `resp_err = 1`. Next state IDLE.
- **Lanes (little-endian):**
  - Byte k = bits [8k+7:8k], k = `addr[1:0]`.
  - Half h = bits [16h+15:16h], h = `addr[1]`.
- **Memory outputs:**
  - `mem_read`/`mem_write`/`mem_address`/`mem_write_data` are decoded combinationally from state plus captured registers.
  - `mem_read` and `mem_write` are never both 1.
  - Address and write data are 0 when neither strobe is high.
- **Response:** `resp_*` are registered and set on the edge leaving LD/MRG/WR/ERR; `resp_valid` drops the next cycle.

## Timing
Accept edge is end of cycle T.
- Word store: `mem_write` in T+1; `resp_valid` in T+2.
- Load: `mem_read` in T+1; `mem_data` sampled in T+2; `resp_valid` with data in T+3.
- Sub-word store: `mem_read` in T+1; merged `mem_write` in T+2; `resp_valid` in T+3.
- Error: ERR in T+1; `resp_valid` with `resp_err` in T+2; zero memory strobes.
- **Back-to-back:** state is IDLE while `resp_valid` is high, so a new request may be accepted in that same cycle. There are no dead cycles between requests.
- **Reset values:** state IDLE; all `resp_*` 0; all `mem_*` 0; `req_ready` 1.
- **Reset mid-operation:** strobes drop asynchronously with the state. A reset in MRG or WR before the edge means no write occurs and the memory word is unchanged. No response is issued for the aborted request.

## Structure
- **Package `mips_mem_pkg`:**
  - Size encodings `SZ_BYTE` / `SZ_HALF` / `SZ_WORD`.
  - LSU state enum.
  - Lane-select helper constants.
- **Sub-module `lsu_lane`:** combinational. Does load extract and extend (`rdata`, `addr[1:0]`, `size`, `signed`) and store merge (`old`, `wdata`, `addr[1:0]`, `size`). Instanced once.

## Test plan
- **Word store then load:** `sw 0xDEADBEEF @0x10` gives `mem_write` in T+1 with `mem_address = 4` and `resp_valid` in T+2. Then `lw @0x10` gives `resp_rdata = 0xDEADBEEF` in T+3.
- **Byte store and loads:** preload word 4 = `0x11223344`. `sb 0xA5 @0x13` gives `mem_read` T+1, `mem_write` T+2 with data `0xA5223344`. Then `lb @0x13` gives `0xFFFFFFA5`, and `lbu @0x13` gives `0x000000A5`.
- **Half store and load:** `sh 0x8001 @0x12` over `0xA5223344` writes `0x80013344`. Then `lh @0x12` gives `0xFFFF8001`, and `lhu @0x10` gives `0x00003344`.
- **Error responses:** each of `lw @0x11`, `lh @0x13`, size 11, and `lw @0x1000` (index 1024) gives `resp_valid` and `resp_err` in T+2 with `rdata = 0`. `mem_read` and `mem_write` stay 0 throughout.
- **Reset during RMW:** assert `rst` during the MRG cycle of an `sb`. Strobes drop immediately, the memory word is unchanged, `resp_valid` stays 0, and `req_ready` is 1 after release.
- **Back-to-back stream:** hold `req_valid` with alternating loads and stores. Each new request is accepted in its predecessor's `resp_valid` cycle, and the assertion `!(mem_read & mem_write)` holds every cycle.
